// File: rtl/onchip_memory_dp.sv
// onchip_memory_dp
//   True dual-port word RAM shared by two Avalon-MM slaves (s1, s2) on one clock.
//   Reads are pipelined: data returns with sN_readdatavalid READ_LATENCY cycles after the
//   accepting edge. Writes are byte-enabled. When both ports write the same word on the same
//   cycle, s1 wins and s2 is stalled for that cycle with s2_waitrequest.
// Ports
//   clk, reset_n        single clock, asynchronous active-low reset (memory is not cleared)
//   clken               global clock enable; low freezes the block and stalls both ports
//   sN_address          word address (no byte-address translation)
//   sN_byteenable       byte lanes for writes
//   sN_chipselect       port select
//   sN_read, sN_write   requests; both together means write only
//   sN_writedata        write data
//   sN_readdata         read data, meaningful while sN_readdatavalid is high, held otherwise
//   sN_readdatavalid    one-cycle strobe per accepted read
//   sN_waitrequest      combinational stall
module onchip_memory_dp #(
   parameter int unsigned DATA_WIDTH   = 32,
   parameter int unsigned DEPTH        = 25000,
   parameter int unsigned ADDR_WIDTH   = 15,
   parameter int unsigned READ_LATENCY = 1,
   parameter string       INIT_FILE    = "UNUSED"
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    clken,
   input  logic [ADDR_WIDTH-1:0]   s1_address,
   input  logic [DATA_WIDTH/8-1:0] s1_byteenable,
   input  logic                    s1_chipselect,
   input  logic                    s1_read,
   input  logic                    s1_write,
   input  logic [DATA_WIDTH-1:0]   s1_writedata,
   output logic [DATA_WIDTH-1:0]   s1_readdata,
   output logic                    s1_readdatavalid,
   output logic                    s1_waitrequest,
   input  logic [ADDR_WIDTH-1:0]   s2_address,
   input  logic [DATA_WIDTH/8-1:0] s2_byteenable,
   input  logic                    s2_chipselect,
   input  logic                    s2_read,
   input  logic                    s2_write,
   input  logic [DATA_WIDTH-1:0]   s2_writedata,
   output logic [DATA_WIDTH-1:0]   s2_readdata,
   output logic                    s2_readdatavalid,
   output logic                    s2_waitrequest
);

   localparam int unsigned NumBytes = DATA_WIDTH / 8;
   // One extra bit so DEPTH == 2**ADDR_WIDTH still compares correctly.
   localparam logic [ADDR_WIDTH:0] DepthW = (ADDR_WIDTH + 1)'(DEPTH);

   // Contents are preloaded by the device programming flow when INIT_FILE names a file.
   (* ram_init_file = INIT_FILE *)
   logic [DATA_WIDTH-1:0] mem [DEPTH];

   logic                  collision;
   logic                  s1_in_range, s2_in_range;
   logic                  s1_wr_acc, s2_wr_acc;
   logic                  s1_rd_acc, s2_rd_acc;
   logic [DATA_WIDTH-1:0] s1_rd_raw, s2_rd_raw;

   always_comb begin
      collision = s1_chipselect & s1_write & s2_chipselect & s2_write &
                  (s1_address == s2_address);
      // Held low during reset so the fabric never sees a stall from a block in reset.
      s1_waitrequest = reset_n & ~clken;
      s2_waitrequest = reset_n & (~clken | collision);

      s1_in_range = ({1'b0, s1_address} < DepthW);
      s2_in_range = ({1'b0, s2_address} < DepthW);

      s1_wr_acc = reset_n & clken & ~s1_waitrequest & s1_chipselect & s1_write;
      s2_wr_acc = reset_n & clken & ~s2_waitrequest & s2_chipselect & s2_write;
      // A simultaneous read+write on one port is treated as a write only.
      s1_rd_acc = reset_n & clken & ~s1_waitrequest & s1_chipselect & s1_read & ~s1_write;
      s2_rd_acc = reset_n & clken & ~s2_waitrequest & s2_chipselect & s2_read & ~s2_write;

      // Sampled before this edge's writes land, so mixed-port read-during-write sees old data.
      s1_rd_raw = s1_in_range ? mem[s1_address] : '0;
      s2_rd_raw = s2_in_range ? mem[s2_address] : '0;
   end

   // Out-of-range writes are accepted but dropped. Same-word writes never reach here together
   // because s2 is stalled on a collision.
   always_ff @(posedge clk) begin
      for (int unsigned i = 0; i < NumBytes; i++) begin
         if (s1_wr_acc && s1_in_range && s1_byteenable[i]) begin
            mem[s1_address][8*i +: 8] <= s1_writedata[8*i +: 8];
         end
         if (s2_wr_acc && s2_in_range && s2_byteenable[i]) begin
            mem[s2_address][8*i +: 8] <= s2_writedata[8*i +: 8];
         end
      end
   end

   if (READ_LATENCY == 2) begin : g_lat2
      logic [DATA_WIDTH-1:0] s1_stg_data, s2_stg_data;
      logic                  s1_stg_vld, s2_stg_vld;

      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            s1_stg_data      <= '0;
            s2_stg_data      <= '0;
            s1_stg_vld       <= 1'b0;
            s2_stg_vld       <= 1'b0;
            s1_readdata      <= '0;
            s2_readdata      <= '0;
            s1_readdatavalid <= 1'b0;
            s2_readdatavalid <= 1'b0;
         end else if (clken) begin
            s1_stg_vld       <= s1_rd_acc;
            s2_stg_vld       <= s2_rd_acc;
            s1_readdatavalid <= s1_stg_vld;
            s2_readdatavalid <= s2_stg_vld;
            if (s1_rd_acc)  s1_stg_data <= s1_rd_raw;
            if (s2_rd_acc)  s2_stg_data <= s2_rd_raw;
            if (s1_stg_vld) s1_readdata <= s1_stg_data;
            if (s2_stg_vld) s2_readdata <= s2_stg_data;
         end
      end
   end else begin : g_lat1
      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            s1_readdata      <= '0;
            s2_readdata      <= '0;
            s1_readdatavalid <= 1'b0;
            s2_readdatavalid <= 1'b0;
         end else if (clken) begin
            s1_readdatavalid <= s1_rd_acc;
            s2_readdatavalid <= s2_rd_acc;
            if (s1_rd_acc) s1_readdata <= s1_rd_raw;
            if (s2_rd_acc) s2_readdata <= s2_rd_raw;
         end
      end
   end

endmodule

// File: tb/tb_onchip_memory_dp.sv
// Testbench for onchip_memory_dp: directed scenarios plus a randomized two-port run, checked
// against a transaction-level model (associative-array memory, per-port pending-read queues).
module tb_onchip_memory_dp;

   localparam int DW    = 32;
   localparam int AW    = 15;
   localparam int DEPTH = 25000;
   localparam int RL    = 2;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          clken = 1'b1;
   logic [AW-1:0] s1_address = '0, s2_address = '0;
   logic [3:0]    s1_byteenable = '0, s2_byteenable = '0;
   logic          s1_chipselect = 1'b0, s2_chipselect = 1'b0;
   logic          s1_read = 1'b0, s2_read = 1'b0;
   logic          s1_write = 1'b0, s2_write = 1'b0;
   logic [DW-1:0] s1_writedata = '0, s2_writedata = '0;
   logic [DW-1:0] s1_readdata, s2_readdata;
   logic          s1_readdatavalid, s2_readdatavalid;
   logic          s1_waitrequest, s2_waitrequest;

   int checks = 0;
   int errors = 0;

   onchip_memory_dp #(
      .DATA_WIDTH  (DW),
      .DEPTH       (DEPTH),
      .ADDR_WIDTH  (AW),
      .READ_LATENCY(RL),
      .INIT_FILE   ("UNUSED")
   ) dut (
      .clk             (clk),
      .reset_n         (reset_n),
      .clken           (clken),
      .s1_address      (s1_address),
      .s1_byteenable   (s1_byteenable),
      .s1_chipselect   (s1_chipselect),
      .s1_read         (s1_read),
      .s1_write        (s1_write),
      .s1_writedata    (s1_writedata),
      .s1_readdata     (s1_readdata),
      .s1_readdatavalid(s1_readdatavalid),
      .s1_waitrequest  (s1_waitrequest),
      .s2_address      (s2_address),
      .s2_byteenable   (s2_byteenable),
      .s2_chipselect   (s2_chipselect),
      .s2_read         (s2_read),
      .s2_write        (s2_write),
      .s2_writedata    (s2_writedata),
      .s2_readdata     (s2_readdata),
      .s2_readdatavalid(s2_readdatavalid),
      .s2_waitrequest  (s2_waitrequest)
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   typedef struct {
      logic [DW-1:0] data;
      int            rem;   // enabled edges still to go before the data is visible
   } pend_t;

   logic [DW-1:0] ref_mem [int];
   pend_t         q1[$], q2[$];
   logic [DW-1:0] last1 = '0, last2 = '0;

   function automatic logic [DW-1:0] model_rd(input logic [AW-1:0] a);
      if (int'(a) >= DEPTH) return '0;
      return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : 'x;
   endfunction

   task automatic model_wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] be);
      logic [DW-1:0] w;
      if (int'(a) >= DEPTH) return;
      w = ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : '0;
      for (int i = 0; i < 4; i++) if (be[i]) w[8*i +: 8] = d[8*i +: 8];
      ref_mem[int'(a)] = w;
   endtask

   task automatic model_reset();
      q1.delete();
      q2.delete();
      last1 = '0;
      last2 = '0;
   endtask

   // One rising edge of the model, evaluated from the inputs the bench is driving.
   task automatic model_step();
      bit w1, w2, r1, r2;
      logic [DW-1:0] d1, d2;
      if (!reset_n || !clken) return;
      w1 = s1_chipselect && s1_write;
      w2 = s2_chipselect && s2_write && !(w1 && s1_address == s2_address);
      r1 = s1_chipselect && s1_read && !s1_write;
      r2 = s2_chipselect && s2_read && !s2_write;
      d1 = model_rd(s1_address);
      d2 = model_rd(s2_address);
      if (q1.size() > 0 && q1[0].rem == 0) begin last1 = q1[0].data; void'(q1.pop_front()); end
      if (q2.size() > 0 && q2[0].rem == 0) begin last2 = q2[0].data; void'(q2.pop_front()); end
      foreach (q1[k]) q1[k].rem -= 1;
      foreach (q2[k]) q2[k].rem -= 1;
      if (r1) q1.push_back('{data: d1, rem: RL - 1});
      if (r2) q2.push_back('{data: d2, rem: RL - 1});
      if (w1) model_wr(s1_address, s1_writedata, s1_byteenable);
      if (w2) model_wr(s2_address, s2_writedata, s2_byteenable);
   endtask

   function automatic logic exp_vld(input int p);
      if (p == 1) return q1.size() > 0 && q1[0].rem == 0;
      return q2.size() > 0 && q2[0].rem == 0;
   endfunction

   function automatic logic [DW-1:0] exp_rd(input int p);
      if (p == 1) return exp_vld(1) ? q1[0].data : last1;
      return exp_vld(2) ? q2[0].data : last2;
   endfunction

   function automatic logic exp_wait(input int p);
      if (!reset_n) return 1'b0;
      if (!clken) return 1'b1;
      if (p == 1) return 1'b0;
      return s1_chipselect && s1_write && s2_chipselect && s2_write && s1_address == s2_address;
   endfunction

   // ---------------- drive helpers ----------------
   task automatic edge_();
      @(posedge clk);
      model_step();
   endtask

   task automatic tick();
      edge_();
      @(negedge clk);
   endtask

   task automatic idle();
      s1_chipselect = 0; s1_read = 0; s1_write = 0;
      s2_chipselect = 0; s2_read = 0; s2_write = 0;
   endtask

   task automatic wr(input int p, input logic [AW-1:0] a, input logic [DW-1:0] d,
                     input logic [3:0] be);
      if (p == 1) begin
         s1_chipselect = 1; s1_read = 0; s1_write = 1;
         s1_address = a; s1_writedata = d; s1_byteenable = be;
      end else begin
         s2_chipselect = 1; s2_read = 0; s2_write = 1;
         s2_address = a; s2_writedata = d; s2_byteenable = be;
      end
   endtask

   task automatic rd(input int p, input logic [AW-1:0] a);
      if (p == 1) begin
         s1_chipselect = 1; s1_read = 1; s1_write = 0; s1_address = a;
      end else begin
         s2_chipselect = 1; s2_read = 1; s2_write = 0; s2_address = a;
      end
   endtask

   task automatic write_word(input int p, input logic [AW-1:0] a, input logic [DW-1:0] d,
                             input logic [3:0] be);
      idle(); wr(p, a, d, be); tick(); idle();
   endtask

   // Issues one read and returns the data and the cycle count to its valid (-1 if none).
   task automatic read_word(input int p, input logic [AW-1:0] a, output logic [DW-1:0] d,
                            output int lat);
      idle(); rd(p, a); tick(); idle();
      lat = -1;
      d = 'x;
      for (int k = 1; k <= 10; k++) begin
         if ((p == 1) ? s1_readdatavalid : s2_readdatavalid) begin
            lat = k;
            d = (p == 1) ? s1_readdata : s2_readdata;
            break;
         end
         tick();
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      repeat (2) @(negedge clk);
      checks++;
      if (s1_readdata !== '0 || s1_readdatavalid !== 1'b0 || s1_waitrequest !== 1'b0) begin
         errors++;
         $display("FAIL reset_s1: got data=%h vld=%b wait=%b, want 0/0/0",
                  s1_readdata, s1_readdatavalid, s1_waitrequest);
      end
      checks++;
      if (s2_readdata !== '0 || s2_readdatavalid !== 1'b0 || s2_waitrequest !== 1'b0) begin
         errors++;
         $display("FAIL reset_s2: got data=%h vld=%b wait=%b, want 0/0/0",
                  s2_readdata, s2_readdatavalid, s2_waitrequest);
      end
      reset_n = 1'b1;
      tick();
   endtask

   task automatic test_write_read();
      logic [DW-1:0] d;
      int lat;
      write_word(1, 'h15, 32'hDEADBEEF, 4'hF);
      read_word(2, 'h15, d, lat);
      checks++;
      if (lat != RL) begin
         errors++; $display("FAIL wr_rd_latency: got %0d, want %0d", lat, RL);
      end
      checks++;
      if (d !== 32'hDEADBEEF) begin
         errors++; $display("FAIL wr_rd_data: got %h, want deadbeef", d);
      end
      tick();
      checks++;
      if (s2_readdatavalid !== 1'b0 || s2_readdata !== 32'hDEADBEEF) begin
         errors++;
         $display("FAIL wr_rd_hold: got vld=%b data=%h, want 0/deadbeef",
                  s2_readdatavalid, s2_readdata);
      end
   endtask

   task automatic test_byte_enable();
      logic [DW-1:0] d;
      int lat;
      write_word(1, 'h20, 32'hAAAAAAAA, 4'hF);
      write_word(1, 'h20, 32'h11223344, 4'b0101);
      read_word(1, 'h20, d, lat);
      checks++;
      if (d !== 32'hAA22AA44 || lat != RL) begin
         errors++; $display("FAIL byte_enable: got %h lat %0d, want aa22aa44 lat %0d", d, lat, RL);
      end
      write_word(2, 'h20, 32'hFFFFFFFF, 4'h0);
      read_word(2, 'h20, d, lat);
      checks++;
      if (d !== 32'hAA22AA44) begin
         errors++; $display("FAIL zero_byte_enable: got %h, want aa22aa44", d);
      end
   endtask

   task automatic test_collision();
      logic [DW-1:0] d;
      int lat;
      idle();
      wr(1, 'h30, 32'h0000FFFF, 4'hF);
      wr(2, 'h30, 32'hFFFF0000, 4'b1100);
      #1;
      checks++;
      if (s2_waitrequest !== 1'b1 || s1_waitrequest !== 1'b0) begin
         errors++;
         $display("FAIL collision_stall: got s1_wait=%b s2_wait=%b, want 0/1",
                  s1_waitrequest, s2_waitrequest);
      end
      tick();
      s1_chipselect = 0; s1_write = 0;  // s2 keeps its request held
      #1;
      checks++;
      if (s2_waitrequest !== 1'b0) begin
         errors++; $display("FAIL collision_release: got s2_wait=%b, want 0", s2_waitrequest);
      end
      tick();
      idle();
      read_word(1, 'h30, d, lat);
      checks++;
      if (d !== 32'hFFFFFFFF) begin
         errors++; $display("FAIL collision_merge: got %h, want ffffffff", d);
      end
      // Different addresses written together never stall.
      wr(1, 'h31, 32'h01010101, 4'hF);
      wr(2, 'h32, 32'h02020202, 4'hF);
      #1;
      checks++;
      if (s2_waitrequest !== 1'b0) begin
         errors++; $display("FAIL diff_addr_no_stall: got s2_wait=%b, want 0", s2_waitrequest);
      end
      tick();
      idle();
      read_word(2, 'h32, d, lat);
      checks++;
      if (d !== 32'h02020202) begin
         errors++; $display("FAIL diff_addr_data: got %h, want 02020202", d);
      end
   endtask

   task automatic test_read_during_write();
      logic [DW-1:0] d;
      int lat;
      write_word(1, 'h40, 32'h9, 4'hF);
      write_word(2, 'h41, 32'h7, 4'hF);
      idle();
      wr(1, 'h40, 32'h5, 4'hF);
      rd(2, 'h40);
      #1;
      checks++;
      if (s2_waitrequest !== 1'b0) begin
         errors++; $display("FAIL rdw_no_stall: got s2_wait=%b, want 0", s2_waitrequest);
      end
      tick();
      idle();
      for (int k = 1; k < RL; k++) tick();
      checks++;
      if (s2_readdatavalid !== 1'b1 || s2_readdata !== 32'h9) begin
         errors++;
         $display("FAIL rdw_old_data: got vld=%b data=%h, want 1/00000009",
                  s2_readdatavalid, s2_readdata);
      end
      read_word(2, 'h40, d, lat);
      checks++;
      if (d !== 32'h5) begin
         errors++; $display("FAIL rdw_new_data: got %h, want 00000005", d);
      end
      // Ports swapped: s2 writes while s1 reads.
      idle();
      wr(2, 'h41, 32'h3, 4'hF);
      rd(1, 'h41);
      tick();
      idle();
      for (int k = 1; k < RL; k++) tick();
      checks++;
      if (s1_readdatavalid !== 1'b1 || s1_readdata !== 32'h7) begin
         errors++;
         $display("FAIL rdw_swapped: got vld=%b data=%h, want 1/00000007",
                  s1_readdatavalid, s1_readdata);
      end
      // Read and write together on one port: write only, no read data.
      idle();
      wr(1, 'h42, 32'hCAFE, 4'hF);
      s1_read = 1;
      tick();
      idle();
      repeat (RL + 1) begin
         checks++;
         if (s1_readdatavalid !== 1'b0) begin
            errors++; $display("FAIL rd_wr_same_port: got vld=%b, want 0", s1_readdatavalid);
         end
         tick();
      end
      read_word(1, 'h42, d, lat);
      checks++;
      if (d !== 32'hCAFE) begin
         errors++; $display("FAIL rd_wr_same_port_data: got %h, want 0000cafe", d);
      end
   endtask

   task automatic test_clken_burst();
      logic [DW-1:0] bd [8];
      logic [DW-1:0] got[$];
      int  i = 0;
      bit  en;
      int  extra = 0;
      for (int k = 0; k < 8; k++) begin
         bd[k] = $urandom;
         write_word(1, AW'(k), bd[k], 4'hF);
      end
      for (int cyc = 0; cyc < 40 && got.size() < 8; cyc++) begin
         clken = !(cyc >= 3 && cyc < 6);
         idle();
         if (i < 8) rd(2, AW'(i));
         #1;
         checks++;
         if (s2_waitrequest !== exp_wait(2)) begin
            errors++;
            $display("FAIL burst_wait: got %b, want %b", s2_waitrequest, exp_wait(2));
         end
         en = clken;
         tick();
         if (en && i < 8) i++;
         checks++;
         if (s2_readdatavalid !== exp_vld(2) || s2_readdata !== exp_rd(2)) begin
            errors++;
            $display("FAIL burst_out: got vld=%b data=%h, want vld=%b data=%h",
                     s2_readdatavalid, s2_readdata, exp_vld(2), exp_rd(2));
         end
         // A valid held through a freeze is one transfer, counted at the edge that made it.
         if (en && s2_readdatavalid) got.push_back(s2_readdata);
      end
      clken = 1'b1;
      idle();
      repeat (4) begin
         tick();
         if (s2_readdatavalid) extra++;
      end
      checks++;
      if (got.size() != 8 || extra != 0) begin
         errors++;
         $display("FAIL burst_count: got %0d valids (+%0d extra), want 8", got.size(), extra);
      end
      for (int k = 0; k < 8 && k < got.size(); k++) begin
         checks++;
         if (got[k] !== bd[k]) begin
            errors++; $display("FAIL burst_order[%0d]: got %h, want %h", k, got[k], bd[k]);
         end
      end
   endtask

   task automatic test_reset_inflight();
      logic [DW-1:0] d;
      int lat;
      int seen = 0;
      write_word(1, 'h50, 32'h50505050, 4'hF);
      write_word(1, 'h51, 32'h51515151, 4'hF);
      idle(); rd(2, 'h50); rd(1, 'h51); tick();
      idle(); rd(2, 'h51); rd(1, 'h50); edge_();
      #1;
      reset_n = 1'b0;
      model_reset();
      #1;
      checks++;
      if (s1_readdatavalid !== 1'b0 || s2_readdatavalid !== 1'b0 ||
          s1_readdata !== '0 || s2_readdata !== '0) begin
         errors++;
         $display("FAIL reset_flush: got vld=%b/%b data=%h/%h, want 0/0 0/0",
                  s1_readdatavalid, s2_readdatavalid, s1_readdata, s2_readdata);
      end
      @(negedge clk);
      idle();
      reset_n = 1'b1;
      repeat (RL + 2) begin
         tick();
         if (s1_readdatavalid || s2_readdatavalid) seen++;
      end
      checks++;
      if (seen != 0) begin
         errors++; $display("FAIL reset_no_return: got %0d stale valids, want 0", seen);
      end
      read_word(2, AW'(DEPTH), d, lat);
      checks++;
      if (d !== '0 || lat != RL) begin
         errors++;
         $display("FAIL out_of_range_read: got %h lat %0d, want 0 lat %0d", d, lat, RL);
      end
      write_word(1, AW'(32767), 32'h12345678, 4'hF);
      read_word(1, AW'(32767), d, lat);
      checks++;
      if (d !== '0) begin
         errors++; $display("FAIL out_of_range_write: got %h, want 0", d);
      end
   endtask

   function automatic logic [AW-1:0] pick_addr();
      if ($urandom_range(7) == 0) return AW'(DEPTH + $urandom_range(32767 - DEPTH));
      return AW'(32'h100 + $urandom_range(15));
   endfunction

   task automatic test_random();
      for (int k = 0; k < 16; k++) write_word(1, AW'(32'h100 + k), $urandom, 4'hF);
      for (int c = 0; c < 300; c++) begin
         checks++;
         if (s1_readdatavalid !== exp_vld(1) || s1_readdata !== exp_rd(1)) begin
            errors++;
            $display("FAIL random_s1[%0d]: got vld=%b data=%h, want vld=%b data=%h", c,
                     s1_readdatavalid, s1_readdata, exp_vld(1), exp_rd(1));
         end
         checks++;
         if (s2_readdatavalid !== exp_vld(2) || s2_readdata !== exp_rd(2)) begin
            errors++;
            $display("FAIL random_s2[%0d]: got vld=%b data=%h, want vld=%b data=%h", c,
                     s2_readdatavalid, s2_readdata, exp_vld(2), exp_rd(2));
         end
         clken         = ($urandom_range(9) != 0);
         s1_chipselect = ($urandom_range(3) != 0);
         s1_read       = 1'($urandom_range(1));
         s1_write      = 1'($urandom_range(1));
         s1_address    = pick_addr();
         s1_byteenable = 4'($urandom);
         s1_writedata  = $urandom;
         s2_chipselect = ($urandom_range(3) != 0);
         s2_read       = 1'($urandom_range(1));
         s2_write      = 1'($urandom_range(1));
         s2_address    = pick_addr();
         s2_byteenable = 4'($urandom);
         s2_writedata  = $urandom;
         #1;
         checks++;
         if (s1_waitrequest !== exp_wait(1) || s2_waitrequest !== exp_wait(2)) begin
            errors++;
            $display("FAIL random_wait[%0d]: got %b/%b, want %b/%b", c,
                     s1_waitrequest, s2_waitrequest, exp_wait(1), exp_wait(2));
         end
         tick();
      end
      clken = 1'b1;
      idle();
      repeat (RL + 1) tick();
      checks++;
      if (s1_readdatavalid !== exp_vld(1) || s2_readdatavalid !== exp_vld(2)) begin
         errors++;
         $display("FAIL random_drain: got %b/%b, want %b/%b",
                  s1_readdatavalid, s2_readdatavalid, exp_vld(1), exp_vld(2));
      end
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_byte_enable();
      test_collision();
      test_read_during_write();
      test_clken_burst();
      test_reset_inflight();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL timeout: simulation did not complete, want completion");
      $fatal(1, "timeout");
   end

endmodule
